sha1_msg_loader: RTL

Writer-side companion to the SHA-1 hasher. It accepts a plaintext byte stream, packs the bytes into 32-bit words and writes them into the shared dual-port SRAM through port B, in the byte layout the hasher reads from port A. It then issues start_hash to the hasher, waits for its done, and writes the 160-bit digest back into the SRAM.

---
 rtl/sha1_msg_loader_pkg.sv | 20 ++
 rtl/sha1_msg_loader_byte_packer.sv | 57 +++++
 rtl/sha1_msg_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sha1_msg_loader_pkg.sv
// Shared types and helpers for the SHA-1 message loader and its byte packer.
// The byte swap matches the lane order the hasher reads through port A.
package sha1_msg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_KICK,
    ST_WAIT,
    ST_DIGEST
  } state_t;

  localparam int unsigned SHA1_WORDS = 5;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha1_msg_loader_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words, or passes whole words
// straight through; the output word is registered and valid for one cycle.
module sha1_byte_packer (
  input  logic        clk,
  input  logic        nreset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  input  logic        word_in_valid,
  input  logic [31:0] word_in,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        word_last
);

  logic [1:0]  lane;
  logic [31:0] acc;
  logic [31:0] merged;

  always_comb begin
    merged = acc | ({24'b0, byte_data} << {lane, 3'b000});
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lane       <= '0;
      acc        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
      word_last  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      if (clear) begin
        lane <= '0;
        acc  <= '0;
      end else if (word_in_valid) begin
        word       <= word_in;
        word_valid <= 1'b1;
      end else if (byte_valid) begin
        // Accumulator restarts at zero so a short final word has zero upper lanes.
        if (lane == 2'd3 || byte_last) begin
          word       <= merged;
          word_valid <= 1'b1;
          word_last  <= byte_last;
          acc        <= '0;
          lane       <= '0;
        end else begin
          acc  <= merged;
          lane <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sha1_msg_loader.sv
// Loads a byte stream into the shared SRAM via port B, kicks the SHA-1 hasher,
// then writes the returned digest back through the same packer.
module sha1_msg_loader
  import sha1_msg_loader_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 16384,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic              empty_msg,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] digest_addr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              port_B_clk,
  output logic [ADDR_W-1:0] port_B_addr,
  output logic [31:0]       port_B_data_in,
  output logic              port_B_we,
  output logic              start_hash,
  output logic [31:0]       message_addr,
  output logic [31:0]       message_size,
  input  logic [159:0]      hash,
  input  logic              hash_done,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t state, state_nx;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] dig_q;
  logic [31:0]       count;
  logic [2:0]        dig_idx;
  logic [159:0]      hash_q;
  logic              wait_first;
  logic              start_acc;
  logic              byte_acc;
  logic              abort;
  logic              dig_wr;
  logic [31:0]       dig_word;
  logic              pk_valid;
  logic [31:0]       pk_word;
  logic              pk_last;

  assign port_B_clk     = clk;
  assign port_B_we      = pk_valid;
  assign port_B_data_in = pk_word;
  assign message_addr   = 32'(base_q);
  assign busy           = (state != ST_IDLE);
  assign dig_word       = bswap32(hash_q[159:128]);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_acc  = 1'b0;
    byte_acc   = 1'b0;
    abort      = 1'b0;
    dig_wr     = 1'b0;
    start_hash = 1'b0;
    in_ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nx  = empty_msg ? ST_KICK : ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (count == 32'(MAX_BYTES)) begin
            abort    = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            byte_acc = 1'b1;
            if (in_last) state_nx = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: state_nx = ST_KICK;
      ST_KICK: begin
        start_hash = 1'b1;
        state_nx   = ST_WAIT;
      end
      ST_WAIT: begin
        // A done level left over from the previous hash is not trusted.
        if (!wait_first && hash_done) state_nx = ST_DIGEST;
      end
      ST_DIGEST: begin
        dig_wr = 1'b1;
        if (dig_idx == 3'(SHA1_WORDS - 1)) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      base_q       <= '0;
      dig_q        <= '0;
      count        <= '0;
      dig_idx      <= '0;
      hash_q       <= '0;
      wait_first   <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      message_size <= '0;
      port_B_addr  <= '0;
    end else begin
      wait_first <= (state == ST_KICK);
      if (start_acc) begin
        base_q       <= base_addr;
        dig_q        <= digest_addr;
        count        <= '0;
        done         <= 1'b0;
        error        <= 1'b0;
        message_size <= '0;
        dig_idx      <= '0;
      end
      if (byte_acc) begin
        count <= count + 32'd1;
        if (in_last || count[1:0] == 2'd3)
          port_B_addr <= base_q + {count[ADDR_W-1:2], 2'b00};
      end
      if (abort) error <= 1'b1;
      // The final message word retires during FLUSH, when count is complete.
      if (pk_last) message_size <= count;
      if (state == ST_WAIT && state_nx == ST_DIGEST) begin
        hash_q  <= hash;
        dig_idx <= '0;
      end
      if (dig_wr) begin
        port_B_addr <= dig_q + ADDR_W'({dig_idx, 2'b00});
        hash_q      <= hash_q << 32;
        dig_idx     <= dig_idx + 3'd1;
        if (state_nx == ST_IDLE) done <= 1'b1;
      end
    end
  end

  sha1_byte_packer u_packer (
    .clk          (clk),
    .nreset       (nreset),
    .clear        (start_acc),
    .byte_valid   (byte_acc),
    .byte_data    (in_data),
    .byte_last    (in_last),
    .word_in_valid(dig_wr),
    .word_in      (dig_word),
    .word_valid   (pk_valid),
    .word         (pk_word),
    .word_last    (pk_last)
  );

endmodule
